// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int INST_BYTES = 4;
    localparam logic [FETCH_XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Small circular queue of fetched {pc, inst} entries with flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_diff;
    fetch_entry_t  r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: contents are only observed when non-empty.
    always_ff @(posedge clk) begin
        if (push && !clear) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    assign w_diff = r_wr_ptr - r_rd_ptr;
    assign count  = CW'(w_diff);
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign rdata  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module : fetch_queue_unit
// Brief  : PC owner, credit-limited imem requester and fetch queue to decode.
//          Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;
    logic [SW-1:0]   w_credit_sum;
    logic            w_accept;
    logic            w_rsp_drop;
    logic            w_rsp_take;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_credit_sum   = SW'(w_count) + SW'(r_outstanding) + SW'(r_drop_cnt);
    // Gated by reset so the request is quiet while reset is held.
    assign imem_req_valid = reset && !redirect_valid && (w_credit_sum < SW'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_rsp_drop     = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_take     = imem_rsp_valid && (r_drop_cnt == '0) && (r_outstanding != '0);
    assign w_push         = w_rsp_take && !redirect_valid;
    assign w_pop          = id_valid && id_ready && !redirect_valid;
    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_wdata        = '{pc: r_rsp_pc, inst: imem_rsp_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still owed by memory becomes wrong-path and must be dropped.
            r_pc          <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(w_rsp_drop || w_rsp_take);
        end else begin
            if (w_accept)   r_pc       <= r_pc + XLEN'(INST_BYTES);
            if (w_rsp_take) r_rsp_pc   <= r_rsp_pc + XLEN'(INST_BYTES);
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_take);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .clear (redirect_valid),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign id_valid = !w_empty;
    assign id_pc    = w_empty ? '0 : w_head.pc;
    assign id_inst  = w_empty ? '0 : w_head.inst;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] r_perf_fetched;
    logic [XLEN-1:0] r_perf_dropped;
    logic [XLEN:0]   w_fetched_sum;
    logic [XLEN:0]   w_dropped_sum;
    logic [CW:0]     w_drop_inc;

    always_comb begin
        w_drop_inc = '0;
        if (redirect_valid) begin
            w_drop_inc = (CW+1)'(w_count) + (CW+1)'(w_rsp_drop || w_rsp_take);
        end else begin
            w_drop_inc = (CW+1)'(w_rsp_drop);
        end
    end

    assign w_fetched_sum = {1'b0, r_perf_fetched} + (XLEN+1)'(w_pop);
    assign w_dropped_sum = {1'b0, r_perf_dropped} + (XLEN+1)'(w_drop_inc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            r_perf_fetched <= w_fetched_sum[XLEN] ? '1 : w_fetched_sum[XLEN-1:0];
            r_perf_dropped <= w_dropped_sum[XLEN] ? '1 : w_dropped_sum[XLEN-1:0];
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`endif

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (r_outstanding != '0 || r_drop_cnt != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (w_push && w_full) |-> w_pop);

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
// Module : tb_fetch_queue_unit
// Brief  : Directed scoreboard bench with a simple latency-programmable imem.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue_unit;

    localparam logic [31:0] MAGIC = 32'h1357_9BDF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    rel = 0;
    int    budget = 0;
    int    acc_cnt = 0;
    int    mem_lat = 1;
    int    pop_cnt = 0;
    int    first_pop_cyc = 0;
    int    last_pop_cyc = 0;
    bit    sb_on = 1'b0;
    logic [31:0] last_acc_addr = '0;
    exp_t  exp_q[$];
    pend_t pend_q[$];

    fetch_queue_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, inst: pc ^ MAGIC});
    endtask

    // Hold reset for a few cycles, then release at a falling edge: that cycle is cycle 0.
    task automatic apply_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        budget = 0;
        sb_on = 1'b0;
        exp_q.delete();
        tick(3);
        reset = 1'b1;
        acc_cnt = 0;
        pop_cnt = 0;
        rel = cyc;
    endtask

    // Memory: one response per accepted request, in order, mem_lat cycles later.
    always begin
        pend_t r;
        @(negedge clk);
        #1;
        if (!reset) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_req_ready = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                r = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = r.addr ^ MAGIC;
            end
            imem_req_ready = (acc_cnt < budget);
            #2;
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                acc_cnt++;
                last_acc_addr = imem_req_addr;
            end
        end
    end

    // Monitor: every handshake to decode is checked against the scoreboard.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (reset && id_valid && id_ready && !redirect_valid) begin
            pop_cnt++;
            if (pop_cnt == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (sb_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual pc=%h inst=%h required=none", id_pc, id_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc !== e.pc || id_inst !== e.inst) begin
                        failures++;
                        $display("FAIL sb_entry actual pc=%h inst=%h required pc=%h inst=%h",
                                 id_pc, id_inst, e.pc, e.inst);
                    end
                end
            end
        end
    end

    initial begin
        // Reset values while reset is held
        tick(3);
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);

        // 1: zero-wait memory, streaming one per cycle after a 2-cycle fill
        apply_reset();
        mem_lat = 1; budget = 8; id_ready = 1'b1; sb_on = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        #2;
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        chk("t1_c0_id_valid", 32'(id_valid), 32'd0);
        tick(2);
        #2;
        chk("t1_c2_id_valid", 32'(id_valid), 32'd1);
        tick(10);
        chk("t1_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_pop_cnt", 32'(pop_cnt), 32'd8);
        chk("t1_first_pop_cyc", 32'(first_pop_cyc - rel), 32'd2);
        chk("t1_last_pop_cyc", 32'(last_pop_cyc - rel), 32'd9);

        // 2: decode stalled, credit caps issue at DEPTH, then drains in order
        apply_reset();
        mem_lat = 1; budget = 5; sb_on = 1'b1;
        for (int i = 0; i < 5; i++) push_exp(32'(i * 4));
        tick(10);
        #2;
        chk("t2_acc_cnt_stalled", 32'(acc_cnt), 32'd4);
        chk("t2_last_addr", last_acc_addr, 32'hC);
        chk("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
        id_ready = 1'b1;
        tick(12);
        chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_acc_cnt_final", 32'(acc_cnt), 32'd5);

        // 3: redirect with two late responses in flight
        apply_reset();
        mem_lat = 3; budget = 2; id_ready = 1'b1; sb_on = 1'b1;
        push_exp(32'h100);
        push_exp(32'h104);
        tick(2);
        redirect_valid = 1'b1; redirect_pc = 32'h100; budget = 4;
        #2;
        chk("t3_no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        tick(1);
        redirect_valid = 1'b0;
        #2;
        chk("t3_new_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_new_req_addr", imem_req_addr, 32'h100);
        tick(12);
        chk("t3_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_acc_cnt", 32'(acc_cnt), 32'd4);

        // 4: redirect coincides with a response and a decode handshake
        apply_reset();
        mem_lat = 2; budget = 3; id_ready = 1'b1; sb_on = 1'b1;
        push_exp(32'h200);
        tick(3);
        redirect_valid = 1'b1; redirect_pc = 32'h200; budget = 4;
        #2;
        chk("t4_id_valid_pre", 32'(id_valid), 32'd1);
        chk("t4_rsp_in_redirect", 32'(imem_rsp_valid), 32'd1);
        tick(1);
        redirect_valid = 1'b0;
        #2;
        chk("t4_id_valid_flushed", 32'(id_valid), 32'd0);
        tick(10);
        chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_acc_cnt", 32'(acc_cnt), 32'd4);

        // 5: misaligned redirect target and PC wrap at the top of the address space
        apply_reset();
        mem_lat = 1; budget = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0106;
        #2;
        chk("t5_no_req_redirect", 32'(imem_req_valid), 32'd0);
        tick(1);
        redirect_valid = 1'b0;
        #2;
        chk("t5_aligned_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_aligned_addr", imem_req_addr, 32'h104);
        tick(1);
        #2;
        chk("t5_addr_held", imem_req_addr, 32'h104);
        tick(1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; budget = 2;
        id_ready = 1'b1; sb_on = 1'b1;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        tick(1);
        redirect_valid = 1'b0;
        #2;
        chk("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick(1);
        #2;
        chk("t5_wrap_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_wrap_addr", imem_req_addr, 32'h0);
        tick(8);
        chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset asserted mid-burst with three responses outstanding
        apply_reset();
        mem_lat = 4; budget = 10;
        tick(5);
        #2;
        chk("t6_pre_id_valid", 32'(id_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_req_addr", imem_req_addr, 32'h0);
        chk("t6_rst_id_valid", 32'(id_valid), 32'd0);
        chk("t6_rst_id_pc", id_pc, 32'h0);
        chk("t6_rst_id_inst", id_inst, 32'h0);
        apply_reset();
        budget = 1;
        #2;
        chk("t6_post_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_post_req_addr", imem_req_addr, 32'h0);
        chk("t6_post_id_valid", 32'(id_valid), 32'd0);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
